// File: rtl/bus_fetch_master_if.sv
// Bus/request bundle for bus_fetch_master.
//   master : the fetch engine's view (drives the 4-bit bus, SYNC, ROM command,
//            request ready and the response).
//   slave  : the environment's view (ROM responders, requester, halt source).
// Signals:
//   halt                        freeze request from the environment
//   data_i / data_o / data_en   split 4-bit shared data bus
//   sync, rom_cmd               bus cycle framing and ROM command strobe
//   req_valid/req_ready/req_addr  fetch request handshake
//   resp_valid/resp_data        one-clock response strobe and fetched byte
interface bus_fetch_master_if;
  logic        halt;
  logic [3:0]  data_i;
  logic [3:0]  data_o;
  logic        data_en;
  logic        sync;
  logic        rom_cmd;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_addr;
  logic        resp_valid;
  logic [7:0]  resp_data;

  modport master (
    input  halt, data_i, req_valid, req_addr,
    output data_o, data_en, sync, rom_cmd, req_ready, resp_valid, resp_data
  );

  modport slave (
    output halt, data_i, req_valid, req_addr,
    input  data_o, data_en, sync, rom_cmd, req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/bus_fetch_master.sv
// Minimal 4004-style bus initiator. Runs the 8-phase bus cycle
// (A1 A2 A3 M1 M2 X1 X2 X3), drives a 12-bit address nibble-wise in A1-A3,
// captures the returned byte in M1/M2 and presents it as a one-clock
// response in X1. One request can be held while a fetch is in flight.
// Ports:
//   clock  system clock
//   reset  synchronous, active-low reset
//   bus    bus_fetch_master_if.master (halt, split data bus, sync, rom_cmd,
//          request handshake, response)
// Parameters:
//   DRIVE_IDLE  1: idle cycles still drive IDLE_ADDR in A1-A3 (no rom_cmd)
//   IDLE_ADDR   address shown on idle cycles when DRIVE_IDLE=1
module bus_fetch_master #(
  parameter bit          DRIVE_IDLE = 1'b0,
  parameter logic [11:0] IDLE_ADDR  = 12'h000
) (
  input  logic              clock,
  input  logic              reset,
  bus_fetch_master_if.master bus
);

  localparam logic [2:0] PH_A1 = 3'd0;
  localparam logic [2:0] PH_A2 = 3'd1;
  localparam logic [2:0] PH_A3 = 3'd2;
  localparam logic [2:0] PH_M1 = 3'd3;
  localparam logic [2:0] PH_M2 = 3'd4;
  localparam logic [2:0] PH_X1 = 3'd5;
  localparam logic [2:0] PH_X3 = 3'd7;

  logic [2:0]  phase;
  logic        pending;
  logic        active;
  logic [11:0] hold_addr;
  logic [11:0] cur_addr;
  logic [3:0]  opr;
  logic [3:0]  opa;
  logic [11:0] drive_addr;

  always_ff @(posedge clock) begin
    if (!reset) begin
      phase     <= PH_X3;
      pending   <= 1'b0;
      active    <= 1'b0;
      hold_addr <= '0;
      cur_addr  <= '0;
      opr       <= '0;
      opa       <= '0;
    end else if (!bus.halt) begin
      phase <= phase + 3'd1;
      // Acceptance and launch never collide: launch needs pending=1,
      // acceptance needs pending=0.
      if (bus.req_valid && !pending) begin
        hold_addr <= bus.req_addr;
        pending   <= 1'b1;
      end
      if (phase == PH_X3) begin
        active <= pending;
        if (pending) begin
          cur_addr <= hold_addr;
          pending  <= 1'b0;
        end
      end
      if (active && phase == PH_M1) opr <= bus.data_i;
      if (active && phase == PH_M2) opa <= bus.data_i;
    end
  end

  // Idle cycles show IDLE_ADDR (only when DRIVE_IDLE) but never assert rom_cmd,
  // so responders ignore them.
  always_comb begin
    bus.data_o  = '0;
    bus.data_en = 1'b0;
    bus.rom_cmd = 1'b0;
    drive_addr  = active ? cur_addr : IDLE_ADDR;
    if (active || DRIVE_IDLE) begin
      case (phase)
        PH_A1: begin bus.data_en = 1'b1; bus.data_o = drive_addr[3:0];  end
        PH_A2: begin bus.data_en = 1'b1; bus.data_o = drive_addr[7:4];  end
        PH_A3: begin
          bus.data_en = 1'b1;
          bus.data_o  = drive_addr[11:8];
          bus.rom_cmd = active;
        end
        default: ;
      endcase
    end
  end

  assign bus.sync       = (phase == PH_X3);
  assign bus.req_ready  = !pending && !bus.halt;
  // Gated by halt so a halt parked in X1 yields exactly one pulse on release.
  assign bus.resp_valid = active && (phase == PH_X1) && !bus.halt;
  assign bus.resp_data  = {opr, opa};

endmodule

// File: tb/tb_bus_fetch_master.sv
module tb_bus_fetch_master;
  logic clock;
  logic reset;

  bus_fetch_master_if b();
  bus_fetch_master_if b2();

  bus_fetch_master #(.DRIVE_IDLE(1'b0), .IDLE_ADDR(12'h000)) dut (
    .clock(clock), .reset(reset), .bus(b));
  bus_fetch_master #(.DRIVE_IDLE(1'b1), .IDLE_ADDR(12'h2F0)) dut_idle (
    .clock(clock), .reset(reset), .bus(b2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [4:0] bus_q[$];   // expected {nibble, rom_cmd} per driven phase
  logic [7:0] resp_q[$];  // expected response bytes
  int         resp_cyc[$];
  int         sync_last = 0, sync_prev = 0;
  logic       sync_d = 1'b0;

  function automatic void check(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endfunction

  // ROM contents (stimulus only).
  function automatic logic [7:0] rom(input logic [11:0] a);
    case (a)
      12'h13C: rom = 8'hA5;
      12'h000: rom = 8'h3C;
      12'h001: rom = 8'h7E;
      default: rom = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // ROM responder: tracks phase from SYNC, latches the address, answers M1/M2.
  logic [2:0]  ph_r = 3'd0;
  logic [11:0] ra = '0;
  logic        sel = 1'b0;
  always @(posedge clock) begin
    if (!b.halt) ph_r <= b.sync ? 3'd0 : ph_r + 3'd1;
  end
  always @(negedge clock) begin
    if (b.sync) sel <= 1'b0;
    if (b.data_en) begin
      case (ph_r)
        3'd0: ra[3:0]  <= b.data_o;
        3'd1: ra[7:4]  <= b.data_o;
        3'd2: begin ra[11:8] <= b.data_o; sel <= b.rom_cmd; end
        default: ;
      endcase
    end
  end
  logic [7:0] rbyte;
  assign rbyte = rom(ra);
  assign b.data_i = (sel && ph_r == 3'd3) ? rbyte[7:4] :
                    (sel && ph_r == 3'd4) ? rbyte[3:0] : 4'h0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: pops scoreboard entries whenever the DUT drives the bus or responds.
  always @(negedge clock) begin
    if (reset) begin
      if (b.data_en) begin
        if (bus_q.size() == 0) check("bus_unexpected", 1, 0);
        else begin
          logic [4:0] e;
          e = bus_q.pop_front();
          check("bus_nibble", {b.data_o, b.rom_cmd}, e);
        end
      end else if (b.rom_cmd) check("rom_cmd_no_en", 1, 0);
      if (b.resp_valid) begin
        resp_cyc.push_back(cyc);
        if (resp_q.size() == 0) check("resp_unexpected", b.resp_data, 0);
        else begin
          logic [7:0] e;
          e = resp_q.pop_front();
          check("resp_data", b.resp_data, e);
        end
      end
      if (b2.resp_valid || b2.rom_cmd) check("idle_dut_activity", 1, 0);
    end
    if (b.sync && !sync_d) begin
      sync_prev = sync_last;
      sync_last = cyc;
    end
    sync_d = b.sync;
  end

  task automatic exp_fetch(input logic [11:0] a, input logic [7:0] d);
    bus_q.push_back({a[3:0], 1'b0});
    bus_q.push_back({a[7:4], 1'b0});
    bus_q.push_back({a[11:8], 1'b1});
    resp_q.push_back(d);
  endtask

  task automatic send(input logic [11:0] a);
    int n;
    b.req_addr  = a;
    b.req_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!b.req_ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("req_accept", b.req_ready, 1);
    @(posedge clock); #1;
    b.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((bus_q.size() != 0 || resp_q.size() != 0) && n < 60) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain", bus_q.size() + resp_q.size(), 0);
  endtask

  task automatic wait_rom_cmd();
    int n;
    n = 0;
    @(negedge clock);
    while (!b.rom_cmd && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("rom_cmd_seen", b.rom_cmd, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int lo;
    reset = 1'b0;
    b.halt = 1'b0; b.req_valid = 1'b0; b.req_addr = '0;
    b2.halt = 1'b0; b2.req_valid = 1'b0; b2.req_addr = '0; b2.data_i = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_sync", b.sync, 1);
    check("rst_data_en", b.data_en, 0);
    check("rst_data_o", b.data_o, 0);
    check("rst_rom_cmd", b.rom_cmd, 0);
    check("rst_resp_valid", b.resp_valid, 0);
    check("rst_resp_data", b.resp_data, 0);
    check("rst_req_ready", b.req_ready, 1);
    @(posedge clock); #1;
    reset = 1'b1;

    // Idle cycles: sync every 8th clock; DRIVE_IDLE instance shows 2F0.
    for (int k = 0; k < 17; k++) begin
      @(negedge clock);
      check("idle_sync", b.sync, (k % 8 == 0) ? 1 : 0);
      check("idle_data_en", b.data_en, 0);
      case (k % 8)
        1: begin check("di_en", b2.data_en, 1); check("di_o", b2.data_o, 4'h0); end
        2: begin check("di_en", b2.data_en, 1); check("di_o", b2.data_o, 4'hF); end
        3: begin check("di_en", b2.data_en, 1); check("di_o", b2.data_o, 4'h2); end
        default: check("di_en", b2.data_en, 0);
      endcase
      @(posedge clock); #1;
    end

    // Single fetch 13C -> A5.
    exp_fetch(12'h13C, 8'hA5);
    send(12'h13C);
    wait_drain();

    // Back-to-back fetches.
    exp_fetch(12'h000, 8'h3C);
    exp_fetch(12'h001, 8'h7E);
    resp_cyc.delete();
    send(12'h000);
    send(12'h001);
    lo = 0;
    @(negedge clock);
    while (!b.req_ready && lo < 20) begin
      lo++;
      @(negedge clock);
    end
    check("b2b_ready_low", lo, 7);
    wait_drain();
    check("b2b_resp_count", resp_cyc.size(), 2);
    if (resp_cyc.size() == 2) check("b2b_spacing", resp_cyc[1] - resp_cyc[0], 8);

    // Halt 5 clocks in M2.
    exp_fetch(12'h2AB, 8'hF1);
    resp_cyc.delete();
    send(12'h2AB);
    wait_rom_cmd();
    @(posedge clock); #1;   // M1
    @(posedge clock); #1;   // M2
    b.halt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("halt_sync", b.sync, 0);
      check("halt_req_ready", b.req_ready, 0);
      check("halt_resp_valid", b.resp_valid, 0);
      @(posedge clock); #1;
    end
    b.halt = 1'b0;
    wait_drain();
    check("halt_resp_count", resp_cyc.size(), 1);
    begin
      int n;
      n = 0;
      @(negedge clock);
      while (!b.sync && n < 20) begin
        @(negedge clock);
        n++;
      end
      @(posedge clock); #1;
      check("halt_sync_period", sync_last - sync_prev, 13);
    end

    // Reset during M1 with a second request pending.
    bus_q.push_back({4'h5, 1'b0});
    bus_q.push_back({4'h5, 1'b0});
    bus_q.push_back({4'h3, 1'b1});
    resp_cyc.delete();
    send(12'h355);
    send(12'h356);
    wait_rom_cmd();
    @(posedge clock); #1;   // M1
    @(negedge clock);
    check("abort_pending_ready", b.req_ready, 0);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("abort_sync", b.sync, 1);
    check("abort_req_ready", b.req_ready, 1);
    check("abort_data_en", b.data_en, 0);
    check("abort_resp_valid", b.resp_valid, 0);
    repeat (20) @(posedge clock);
    #1;
    check("abort_no_resp", resp_cyc.size(), 0);
    check("abort_bus_q", bus_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
